// File: rtl/ibus_responder.sv
// Instruction-bus fetch responder: turns a held fetch request into a single
// synchronous memory read, with optional wait states, fault screening and a response counter.
package ibus_pkg;
  typedef struct packed {
    logic        valid;
    logic [63:0] addr;
  } ibus_req_t;

  typedef struct packed {
    logic        addr_ok;
    logic        data_ok;
    logic [31:0] data;
  } ibus_resp_t;
endpackage

module ibus_responder
  import ibus_pkg::*;
#(
  parameter int unsigned WAIT_CYCLES = 0,
  parameter int unsigned MEM_AW      = 12,
  parameter logic [63:0] BASE        = 64'h8000_0000
) (
  input  logic              clk,
  input  logic              rst,
  input  ibus_req_t         ibus_req,
  output ibus_resp_t        ibus_resp,
  output logic              mem_en,
  output logic [MEM_AW-1:0] mem_addr,
  input  logic [31:0]       mem_rdata,
  output logic              fault,
  output logic [31:0]       resp_count
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_READ = 2'd2,
    S_RESP = 2'd3
  } state_t;

  localparam logic [3:0] WAIT_LD   = 4'(WAIT_CYCLES);
  localparam logic       HAS_WAITS = (WAIT_CYCLES != 0);

  state_t      state_q, state_d;
  logic [63:0] req_addr_q, req_addr_d;
  logic [3:0]  wcnt_q, wcnt_d;
  logic        flt_q, flt_d;
  logic [31:0] cnt_q, cnt_d;
  logic        match_s;

  // Misaligned, below the window, or past the last backing word.
  function automatic logic addr_fault(input logic [63:0] a);
    logic [63:0] off;
    off = a - BASE;
    return (a[1:0] != 2'b00) || (a < BASE) || ((off >> (MEM_AW + 2)) != 64'd0);
  endfunction

  function automatic logic [MEM_AW-1:0] word_index(input logic [63:0] a);
    return MEM_AW'((a - BASE) >> 2);
  endfunction

  assign match_s = ibus_req.valid && (ibus_req.addr == req_addr_q);

  // State and transaction registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= S_IDLE;
      req_addr_q <= 64'd0;
      wcnt_q     <= 4'd0;
      flt_q      <= 1'b0;
      cnt_q      <= 32'd0;
    end else begin
      state_q    <= state_d;
      req_addr_q <= req_addr_d;
      wcnt_q     <= wcnt_d;
      flt_q      <= flt_d;
      cnt_q      <= cnt_d;
    end
  end

  // Next-state logic; RESP accepts a new request exactly like IDLE.
  always_comb begin
    state_d    = state_q;
    req_addr_d = req_addr_q;
    wcnt_d     = wcnt_q;
    flt_d      = flt_q;
    cnt_d      = (state_q == S_RESP) ? (cnt_q + 32'd1) : cnt_q;
    case (state_q)
      S_IDLE, S_RESP: begin
        if (ibus_req.valid) begin
          req_addr_d = ibus_req.addr;
          flt_d      = addr_fault(ibus_req.addr);
          wcnt_d     = WAIT_LD;
          state_d    = HAS_WAITS ? S_WAIT : S_READ;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_WAIT: begin
        wcnt_d = wcnt_q - 4'd1;
        if (!match_s) begin
          state_d = S_IDLE;
        end else if (wcnt_q == 4'd1) begin
          state_d = S_READ;
        end else begin
          state_d = S_WAIT;
        end
      end
      S_READ: begin
        if (match_s) begin
          state_d = S_RESP;
        end else begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Outputs decode only from registered state, so reset forces them low at once.
  always_comb begin
    ibus_resp = '0;
    mem_en    = 1'b0;
    mem_addr  = '0;
    fault     = 1'b0;
    case (state_q)
      S_READ: begin
        mem_en   = !flt_q;
        mem_addr = word_index(req_addr_q);
      end
      S_RESP: begin
        ibus_resp.addr_ok = 1'b1;
        ibus_resp.data_ok = 1'b1;
        ibus_resp.data    = flt_q ? 32'h0 : mem_rdata;
        fault             = flt_q;
      end
      default: begin
        ibus_resp = '0;
      end
    endcase
  end

  assign resp_count = cnt_q;

endmodule

// File: tb/tb_ibus_responder.sv
// Randomized scoreboard bench for ibus_responder: the driver predicts responses and
// memory reads per transaction; a negedge monitor pops and compares them.
module tb_ibus_responder;
  import ibus_pkg::*;

  localparam int          W      = 2;
  localparam int          MAW    = 6;
  localparam int          DEPTH  = 1 << MAW;
  localparam logic [63:0] BASE   = 64'h8000_0000;

  logic             clk = 1'b0;
  logic             rst;
  ibus_req_t        req;
  ibus_resp_t       resp;
  logic             mem_en;
  logic [MAW-1:0]   mem_addr;
  logic [31:0]      mem_rdata;
  logic             fault;
  logic [31:0]      resp_count;

  ibus_responder #(.WAIT_CYCLES(W), .MEM_AW(MAW), .BASE(BASE)) dut (
    .clk(clk), .rst(rst), .ibus_req(req), .ibus_resp(resp), .mem_en(mem_en),
    .mem_addr(mem_addr), .mem_rdata(mem_rdata), .fault(fault), .resp_count(resp_count)
  );

  always #5 clk = ~clk;

  typedef struct { logic [31:0] data; logic flt; int cyc; } rsp_t;
  typedef struct { int idx; int cyc; } rd_t;

  rsp_t        rsp_q[$];
  rd_t         rd_q[$];
  logic [31:0] mem [DEPTH];
  logic [31:0] model_cnt = 32'd0;
  int          cyc = 0;
  int          total = 0;
  int          bad = 0;
  rsp_t        mon_r;
  rd_t         mon_m;

  always @(posedge clk) cyc <= cyc + 1;

  // Memory model: read data valid the cycle after mem_en, garbage otherwise.
  always @(posedge clk) mem_rdata <= mem_en ? mem[mem_addr] : $urandom();

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  function automatic logic is_fault(input logic [63:0] a);
    return (a % 64'd4 != 64'd0) || (a < BASE) || ((a - BASE) / 64'd4 >= 64'(DEPTH));
  endfunction

  function automatic int word_of(input logic [63:0] a);
    return int'((a - BASE) / 64'd4);
  endfunction

  function automatic logic [63:0] gen_addr();
    int sel;
    logic [63:0] a;
    sel = $urandom_range(0, 9);
    if (sel < 6)       a = BASE + 64'(4 * $urandom_range(0, DEPTH - 1));
    else if (sel == 6) a = BASE + 64'(4 * $urandom_range(0, DEPTH - 1)) + 64'($urandom_range(1, 3));
    else if (sel == 7) a = BASE - 64'(4 * $urandom_range(1, 16));
    else if (sel == 8) a = BASE + 64'(4 * DEPTH) + 64'(4 * $urandom_range(0, 16));
    else               a = BASE + 64'(4 * (DEPTH - 1));
    return a;
  endfunction

  task automatic drive(input logic v, input logic [63:0] a);
    req.valid = v;
    req.addr  = a;
    @(posedge clk);
    #1;
  endtask

  // Request held through accept, waits and read; response due 2+W cycles after accept.
  task automatic full_txn(input logic [63:0] a);
    rsp_t r;
    rd_t  m;
    logic f;
    f     = is_fault(a);
    r.flt = f;
    r.data = f ? 32'd0 : mem[word_of(a)];
    r.cyc = cyc + 2 + W;
    rsp_q.push_back(r);
    if (!f) begin
      m.idx = word_of(a);
      m.cyc = cyc + 1 + W;
      rd_q.push_back(m);
    end
    for (int i = 0; i < 2 + W; i++) drive(1'b1, a);
  endtask

  // Held for k cycles after accept, then withdrawn or retargeted: no response.
  task automatic abort_txn(input logic [63:0] a, input int k, input logic retarget);
    rd_t  m;
    int   c;
    c = cyc;
    if (k == W && !is_fault(a)) begin
      m.idx = word_of(a);
      m.cyc = c + 1 + W;
      rd_q.push_back(m);
    end
    drive(1'b1, a);
    for (int i = 0; i < k; i++) drive(1'b1, a);
    drive(retarget, a + 64'd4);
  endtask

  // Reset pulsed while the FSM waits; a fresh request is accepted on the first edge after release.
  task automatic reset_txn(input logic [63:0] a);
    drive(1'b0, 64'd0);
    drive(1'b0, 64'd0);
    drive(1'b1, a);
    #1 rst = 1'b0;
    model_cnt = 32'd0;
    #1;
    chk("rst_resp", 64'(resp), 64'd0);
    chk("rst_mem_en", 64'(mem_en), 64'd0);
    chk("rst_fault", 64'(fault), 64'd0);
    chk("rst_count", 64'(resp_count), 64'd0);
    #1 rst = 1'b1;
    full_txn(gen_addr());
  endtask

  // Scoreboard monitor, sampling on the falling edge.
  always @(negedge clk) begin
    chk("resp_count", 64'(resp_count), 64'(model_cnt));
    if (resp.data_ok) begin
      if (rsp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_resp: got data_ok=1 expected none (cycle %0d)", cyc);
      end else begin
        mon_r = rsp_q.pop_front();
        chk("resp_cycle", 64'(cyc), 64'(mon_r.cyc));
        chk("addr_ok", 64'(resp.addr_ok), 64'd1);
        chk("data", 64'(resp.data), 64'(mon_r.data));
        chk("fault", 64'(fault), 64'(mon_r.flt));
      end
      model_cnt = model_cnt + 32'd1;
    end else begin
      chk("idle_outputs", 64'({resp, fault}), 64'd0);
    end
    if (mem_en) begin
      if (rd_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_mem_en: got mem_en=1 addr=%0h expected none (cycle %0d)", mem_addr, cyc);
      end else begin
        mon_m = rd_q.pop_front();
        chk("mem_cycle", 64'(cyc), 64'(mon_m.cyc));
        chk("mem_addr", 64'(mem_addr), 64'(mon_m.idx));
      end
    end
  end

  initial begin
    logic [63:0] a;
    logic [63:0] last_a;
    int          sel;
    int          gap;
    for (int i = 0; i < DEPTH; i++) mem[i] = $urandom();
    rst = 1'b0;
    req = '0;
    #3;
    chk("init_resp", 64'(resp), 64'd0);
    chk("init_mem_en", 64'(mem_en), 64'd0);
    chk("init_count", 64'(resp_count), 64'd0);
    @(posedge clk);
    #1 rst = 1'b1;

    for (int i = 0; i < 8; i++) full_txn(BASE + 64'(4 * i));
    drive(1'b0, 64'd0);
    full_txn(BASE + 64'd2);
    full_txn(BASE - 64'd4);
    drive(1'b0, 64'd0);
    abort_txn(BASE, 0, 1'b1);
    full_txn(BASE + 64'd4);
    full_txn(BASE + 64'd4);

    last_a = BASE;
    for (int n = 0; n < 300; n++) begin
      sel = $urandom_range(0, 9);
      a = ($urandom_range(0, 4) == 0) ? last_a : gen_addr();
      if (sel < 6) begin
        full_txn(a);
        last_a = a;
        gap = $urandom_range(0, 2);
        for (int g = 0; g < gap; g++) drive(1'b0, {$urandom(), $urandom()});
      end else if (sel < 9) begin
        abort_txn(a, $urandom_range(0, W), 1'($urandom_range(0, 1)));
      end else begin
        reset_txn(a);
      end
    end

    for (int t = 0; t < 50 && (rsp_q.size() != 0 || rd_q.size() != 0); t++) drive(1'b0, 64'd0);
    drive(1'b0, 64'd0);
    chk("pending_resps", 64'(rsp_q.size()), 64'd0);
    chk("pending_reads", 64'(rd_q.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ibus_responder.md
IBUS_RESPONDER -- requirements
Module: ibus_responder

Interface
REQ-001 SHALL have parameter WAIT_CYCLES, default 0, meaning extra wait states inserted before each memory read (range 0..15).
REQ-002 SHALL have parameter MEM_AW, default 12, meaning word-address width of the backing memory (2^MEM_AW 32-bit words).
REQ-003 SHALL have parameter BASE, default 64'h8000_0000, meaning byte address mapped to memory word 0.
REQ-004 SHALL have port clk  input  1  single clock; all state on posedge.
REQ-005 SHALL have port rst  input  1  asynchronous, active-low reset (asserted when 0).
REQ-006 SHALL have port ibus_req  input  ibus_req_t  fetch request: valid (1), addr (u64 byte address).
REQ-007 SHALL have port ibus_resp  output  ibus_resp_t  response: addr_ok (1), data_ok (1), data (32).
REQ-008 SHALL have port mem_en  output  1  synchronous memory read enable.
REQ-009 SHALL have port mem_addr  output  MEM_AW  memory word index.
REQ-010 SHALL have port mem_rdata  input  32  memory read data, valid the cycle after mem_en.
REQ-011 SHALL have port fault  output  1  one-cycle pulse with a faulting response.
REQ-012 SHALL have port resp_count  output  32  number of completed responses.

Function
REQ-013 SHALL implement FSM states IDLE, WAIT, READ, RESP.
REQ-014 IDLE: on ibus_req.valid=1, latch addr into req_addr, compute fault flag, load wait counter with WAIT_CYCLES, go to WAIT if WAIT_CYCLES>0 else READ; otherwise stay in IDLE.
REQ-015 Fault flag SHALL be set when addr[1:0]!=0, addr<BASE, or (addr-BASE)>>2 >= 2^MEM_AW.
REQ-016 WAIT: decrement counter each cycle; go to READ in the cycle after the counter reaches 1.
REQ-017 READ: mem_en=1 only if fault flag clear; mem_addr=(req_addr-BASE)>>2 truncated to MEM_AW bits; go to RESP next cycle.
REQ-018 RESP: addr_ok=1 and data_ok=1 for exactly this cycle; data=mem_rdata, or 32'h0 with fault=1 when fault flag set.
REQ-019 Outside RESP, addr_ok, data_ok, fault and mem_en SHALL be 0 (mem_en except READ), and data SHALL be 32'h0.
REQ-020 Latency from accepting cycle N to RESP SHALL be N+2+WAIT_CYCLES.
REQ-021 RESP SHALL behave as IDLE for acceptance: if ibus_req.valid=1 in RESP, a new transaction starts in the same cycle (back-to-back, no idle bubble).
REQ-022 Withdrawal: in WAIT or READ, if ibus_req.valid=0 or ibus_req.addr!=req_addr, the transaction SHALL be aborted (no RESP, no count) and the FSM SHALL return to IDLE next cycle.
REQ-023 A request with unchanged addr presented again after its RESP SHALL be served as a new transaction.
REQ-024 resp_count SHALL increment by 1 at each RESP cycle (faulting included) and wrap from 32'hFFFF_FFFF to 0.
REQ-025 mem_rdata SHALL be ignored outside RESP.

Reset
REQ-026 On rst=0, asynchronously: state=IDLE, req_addr=0, wait counter=0, fault flag=0, resp_count=0; all outputs 0.
REQ-027 Reset asserted mid-transaction SHALL discard it; no RESP is produced after release.
REQ-028 After rst rises, the first request SHALL be acceptable on the first posedge.

Verification
REQ-029 WAIT_CYCLES=0, valid=1 addr=BASE+8 at cycle 0, mem word 2=32'h0000_0013 -> mem_en/mem_addr=2 at cycle 1; addr_ok=data_ok=1, data=32'h13 at cycle 2; resp_count=1.
REQ-030 WAIT_CYCLES=3, addr=BASE held -> single RESP at cycle 5, no mem_en before cycle 4.
REQ-031 addr=BASE+2, then addr=BASE-4 -> each RESP with data=0, fault=1, mem_en never asserted; resp_count=2.
REQ-032 WAIT_CYCLES=2, addr changed BASE->BASE+4 in cycle 1 -> no RESP for BASE; FSM in IDLE at cycle 2; then BASE+4 served with RESP at cycle 2+2+WAIT_CYCLES=6 (accepted cycle 2).
REQ-033 valid held high with addr stepping +4 each RESP -> RESP every 2+WAIT_CYCLES cycles, data matching consecutive words.
REQ-034 rst=0 pulsed during WAIT, and resp_count preloaded via 2^32 responses (or forced) -> all outputs 0 immediately; counter wraps to 0 on the overflowing RESP.
